player_input_conditioner: RTL and testbench

- Upstream stage of the player movement/attack FSM.
- Takes raw asynchronous board buttons and produces clean, frame-aligned btn_left / btn_right / btn_attack levels.
- Synchronises and debounces each button on the fast system clock. Captures attack presses that occur between frames.
- Outputs change only on frame_tick, so they are stable for a whole 60 Hz game frame.

---
 rtl/player_input_conditioner_pkg.sv | 12 +
 rtl/player_input_conditioner_button_debouncer.sv | 46 ++++
 rtl/player_input_conditioner.sv | 85 ++++++++
 tb/tb_player_input_conditioner.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_input_conditioner_pkg.sv
// Shared constants for the player input conditioner: input slot indices and
// the default debounce length (10 ms at 50 MHz).
package player_input_conditioner_pkg;

    localparam int unsigned IN_LEFT    = 0;
    localparam int unsigned IN_RIGHT   = 1;
    localparam int unsigned IN_ATTACK  = 2;
    localparam int unsigned NUM_INPUTS = 3;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/player_input_conditioner_button_debouncer.sv
// One button channel: polarity normalisation, 2-flop synchroniser, saturating
// debounce counter, stable level and a one-clk press (rising) pulse.
module button_debouncer
    import player_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;
    logic          stable_prev;

    // Internal level is 1 = pressed; reset leaves everything at "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= '0;
            cnt         <= '0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], raw ^ ACTIVE_LOW};
            stable_prev <= stable;
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb rise = stable & ~stable_prev;

endmodule

// File: rtl/player_input_conditioner.sv
// Button conditioner feeding the player FSM: debounced, frame-aligned move/attack
// levels. Optional macro SOCD_NEUTRAL_EN forces left+right together to neutral.
module player_input_conditioner
    import player_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic raw_left,
    input  logic raw_right,
    input  logic raw_attack,
    output logic btn_left,
    output logic btn_right,
    output logic btn_attack,
    output logic attack_overrun
);

    logic [NUM_INPUTS-1:0] raw_vec;
    logic [NUM_INPUTS-1:0] stable;
    logic [NUM_INPUTS-1:0] rise;
    logic                  move_left;
    logic                  move_right;
    logic                  attack_rise;
    logic                  attack_pending;
    logic                  unused_bits;

    always_comb begin
        raw_vec            = '0;
        raw_vec[IN_LEFT]   = raw_left;
        raw_vec[IN_RIGHT]  = raw_right;
        raw_vec[IN_ATTACK] = raw_attack;
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debouncer (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_vec[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    always_comb begin
        move_left  = stable[IN_LEFT];
        move_right = stable[IN_RIGHT];
`ifdef SOCD_NEUTRAL_EN
        if (stable[IN_LEFT] && stable[IN_RIGHT]) begin
            move_left  = 1'b0;
            move_right = 1'b0;
        end
`endif
    end

    always_comb attack_rise = rise[IN_ATTACK];
    always_comb unused_bits = ^{rise[IN_LEFT], rise[IN_RIGHT], stable[IN_ATTACK]};

    // A rise on the tick cycle is consumed by that frame, never carried over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_left       <= 1'b0;
            btn_right      <= 1'b0;
            btn_attack     <= 1'b0;
            attack_pending <= 1'b0;
            attack_overrun <= 1'b0;
        end else begin
            attack_overrun <= attack_rise & attack_pending & ~frame_tick;
            if (frame_tick) begin
                btn_left       <= move_left;
                btn_right      <= move_right;
                btn_attack     <= attack_pending | attack_rise;
                attack_pending <= 1'b0;
            end else if (attack_rise) begin
                attack_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Self-checking bench for player_input_conditioner with a windowed debounce
// reference model and directed frame-count checks.
module tb_player_input_conditioner;

    localparam int D     = 4;
    localparam int FRAME = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_tick = 1'b0;
    logic raw_left = 1'b1;
    logic raw_right = 1'b1;
    logic raw_attack = 1'b1;
    logic btn_left, btn_right, btn_attack, attack_overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit force_tick = 1'b0;

    player_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .raw_left       (raw_left),
        .raw_right      (raw_right),
        .raw_attack     (raw_attack),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_attack     (btn_attack),
        .attack_overrun (attack_overrun)
    );

    always #5 clk = ~clk;

    // Reference model: a button's stable level flips once the synchronised
    // (2-clk delayed) pressed level has disagreed with it for D straight clocks.
    bit h [3][D+2];
    bit m_stable [3];
    bit nxt [3];
    bit p [3];
    bit m_prev_att, m_pending, m_l, m_r, m_a, m_o;
    bit m_rise, m_diff, m_ml, m_mr;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_stable[i] = 1'b0;
                for (int k = 0; k < D + 2; k++) h[i][k] = 1'b0;
            end
            m_prev_att = 0; m_pending = 0;
            m_l = 0; m_r = 0; m_a = 0; m_o = 0;
        end else begin
            p[0] = ~raw_left; p[1] = ~raw_right; p[2] = ~raw_attack;
            for (int i = 0; i < 3; i++) begin
                for (int k = D + 1; k > 0; k--) h[i][k] = h[i][k-1];
                h[i][0] = p[i];
                m_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++)
                    if (h[i][k] == m_stable[i]) m_diff = 1'b0;
                nxt[i] = m_diff ? ~m_stable[i] : m_stable[i];
            end
            m_rise = m_stable[2] && !m_prev_att;
            m_o = m_rise && m_pending && !frame_tick;
            if (frame_tick) begin
                m_ml = m_stable[0];
                m_mr = m_stable[1];
`ifdef SOCD_NEUTRAL_EN
                if (m_ml && m_mr) begin m_ml = 0; m_mr = 0; end
`endif
                m_l = m_ml; m_r = m_mr;
                m_a = m_pending || m_rise;
                m_pending = 1'b0;
            end else if (m_rise) begin
                m_pending = 1'b1;
            end
            m_prev_att = m_stable[2];
            for (int i = 0; i < 3; i++) m_stable[i] = nxt[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        frame_tick = ((cyc % FRAME) == 0) || force_tick;
    endtask

    task automatic align(input int off);
        while ((cyc % FRAME) != off) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({btn_left, btn_right, btn_attack, attack_overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0000", {btn_left, btn_right, btn_attack, attack_overrun});
        end
        step();
        reset = 1'b0;
        for (int n = 0; n < 3 * FRAME; n++) begin
            step();
            @(negedge clk);
            checks++;
            if ({btn_left, btn_right, btn_attack} !== 3'b000) begin
                errors++;
                $display("FAIL idle_after_reset cyc=%0d got=%b want=000", cyc, {btn_left, btn_right, btn_attack});
            end
        end
    endtask

    task automatic test_glitch();
        int len;
        for (int g = 0; g < 4; g++) begin
            len = $urandom_range(1, D - 1);
            align($urandom_range(5, 30));
            raw_right = 1'b0;
            for (int n = 1; n <= 2 * FRAME; n++) begin
                step();
                if (n == len) raw_right = 1'b1;
                @(negedge clk);
                checks++;
                if (btn_right !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_right len=%0d cyc=%0d got=%b want=0", len, cyc, btn_right);
                end
                checks++;
                if ({btn_left, btn_right, btn_attack, attack_overrun} !== {m_l, m_r, m_a, m_o}) begin
                    errors++;
                    $display("FAIL glitch_model cyc=%0d got=%b want=%b", cyc,
                             {btn_left, btn_right, btn_attack, attack_overrun}, {m_l, m_r, m_a, m_o});
                end
            end
        end
    endtask

    task automatic test_held_move();
        int hi = 0;
        align(10);
        raw_left = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (n == 200) raw_left = 1'b1;
            @(negedge clk);
            hi += int'(btn_left);
            checks++;
            if ({btn_left, btn_right, btn_attack, attack_overrun} !== {m_l, m_r, m_a, m_o}) begin
                errors++;
                $display("FAIL held_model cyc=%0d got=%b want=%b", cyc,
                         {btn_left, btn_right, btn_attack, attack_overrun}, {m_l, m_r, m_a, m_o});
            end
        end
        checks++;
        if (hi != 200) begin
            errors++;
            $display("FAIL held_left_cycles got=%0d want=200", hi);
        end
    endtask

    task automatic test_attack_tap();
        int hi, len, run;
        for (int t = 0; t < 4; t++) begin
            hi = 0;
            len = (t == 3) ? 150 : $urandom_range(D + 1, 10);
            run = (t == 3) ? 250 : 150;
            align((t == 3) ? 10 : $urandom_range(5, 20));
            raw_attack = 1'b0;
            for (int n = 1; n <= run; n++) begin
                step();
                if (n == len) raw_attack = 1'b1;
                @(negedge clk);
                hi += int'(btn_attack);
                checks++;
                if ({btn_left, btn_right, btn_attack, attack_overrun} !== {m_l, m_r, m_a, m_o}) begin
                    errors++;
                    $display("FAIL tap_model cyc=%0d got=%b want=%b", cyc,
                             {btn_left, btn_right, btn_attack, attack_overrun}, {m_l, m_r, m_a, m_o});
                end
            end
            checks++;
            if (hi != FRAME) begin
                errors++;
                $display("FAIL tap_attack_cycles len=%0d got=%0d want=%0d", len, hi, FRAME);
            end
        end
    endtask

    task automatic test_overrun();
        int hi = 0, ovr = 0;
        int l1, gp, l2;
        l1 = $urandom_range(5, 8);
        gp = $urandom_range(5, 8);
        l2 = $urandom_range(5, 8);
        align(2);
        raw_attack = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            step();
            if (n == l1) raw_attack = 1'b1;
            if (n == l1 + gp) raw_attack = 1'b0;
            if (n == l1 + gp + l2) raw_attack = 1'b1;
            @(negedge clk);
            hi += int'(btn_attack);
            ovr += int'(attack_overrun);
            checks++;
            if ({btn_left, btn_right, btn_attack, attack_overrun} !== {m_l, m_r, m_a, m_o}) begin
                errors++;
                $display("FAIL overrun_model cyc=%0d got=%b want=%b", cyc,
                         {btn_left, btn_right, btn_attack, attack_overrun}, {m_l, m_r, m_a, m_o});
            end
        end
        checks++;
        if (ovr != 1) begin
            errors++;
            $display("FAIL overrun_pulses got=%0d want=1", ovr);
        end
        checks++;
        if (hi != FRAME) begin
            errors++;
            $display("FAIL overrun_attack_cycles got=%0d want=%0d", hi, FRAME);
        end
    endtask

    task automatic test_coincident();
        int hi = 0, ovr = 0;
        align(FRAME - 6);
        raw_attack = 1'b0;
        for (int n = 1; n <= 150; n++) begin
            step();
            if (n == 10) raw_attack = 1'b1;
            @(negedge clk);
            hi += int'(btn_attack);
            ovr += int'(attack_overrun);
        end
        checks++;
        if (hi != FRAME) begin
            errors++;
            $display("FAIL coincident_attack_cycles got=%0d want=%0d", hi, FRAME);
        end
        checks++;
        if (ovr != 0) begin
            errors++;
            $display("FAIL coincident_overrun got=%0d want=0", ovr);
        end
    endtask

    task automatic test_back_to_back_ticks();
        int hi = 0;
        align(5);
        raw_attack = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            force_tick = (n == 43) || (n == 44);
            step();
            if (n == 8) raw_attack = 1'b1;
            @(negedge clk);
            hi += int'(btn_attack);
            checks++;
            if ({btn_left, btn_right, btn_attack, attack_overrun} !== {m_l, m_r, m_a, m_o}) begin
                errors++;
                $display("FAIL b2b_model cyc=%0d got=%b want=%b", cyc,
                         {btn_left, btn_right, btn_attack, attack_overrun}, {m_l, m_r, m_a, m_o});
            end
        end
        force_tick = 1'b0;
        checks++;
        if (hi != 1) begin
            errors++;
            $display("FAIL b2b_attack_cycles got=%0d want=1", hi);
        end
    endtask

    task automatic test_both_dirs();
        logic [1:0] want_both;
`ifdef SOCD_NEUTRAL_EN
        want_both = 2'b00;
`else
        want_both = 2'b11;
`endif
        align(10);
        raw_left = 1'b0;
        raw_right = 1'b0;
        for (int n = 1; n <= 160; n++) begin
            step();
            if (n == 100) raw_right = 1'b1;
            @(negedge clk);
            if (n == 95) begin
                checks++;
                if ({btn_left, btn_right} !== want_both) begin
                    errors++;
                    $display("FAIL both_dirs got=%b want=%b", {btn_left, btn_right}, want_both);
                end
            end
            if (n == 160) begin
                checks++;
                if ({btn_left, btn_right} !== 2'b10) begin
                    errors++;
                    $display("FAIL right_released got=%b want=10", {btn_left, btn_right});
                end
            end
        end
        raw_left = 1'b1;
        repeat (2 * FRAME) step();
    endtask

    task automatic test_reset_mid();
        int hi = 0;
        align(5);
        raw_attack = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            step();
            if (n == 8) raw_attack = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({btn_left, btn_right, btn_attack, attack_overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs got=%b want=0000", {btn_left, btn_right, btn_attack, attack_overrun});
        end
        step();
        step();
        reset = 1'b0;
        for (int n = 1; n <= 120; n++) begin
            step();
            @(negedge clk);
            hi += int'(btn_attack);
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL midreset_attack_cycles got=%0d want=0", hi);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            force_tick = ($urandom_range(0, 63) == 0);
            step();
            if ($urandom_range(0, 7) == 0) raw_left = ~raw_left;
            if ($urandom_range(0, 7) == 0) raw_right = ~raw_right;
            if ($urandom_range(0, 5) == 0) raw_attack = ~raw_attack;
            @(negedge clk);
            checks++;
            if ({btn_left, btn_right, btn_attack, attack_overrun} !== {m_l, m_r, m_a, m_o}) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%b want=%b", cyc,
                         {btn_left, btn_right, btn_attack, attack_overrun}, {m_l, m_r, m_a, m_o});
            end
        end
        force_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_held_move();
        test_attack_tap();
        test_overrun();
        test_coincident();
        test_back_to_back_ticks();
        test_both_dirs();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

endmodule
